// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing defaults and types for the 640x480@60 scanout path.
//   - default horizontal/vertical timing (pixels / lines)
//   - h_total / v_total derivation helpers
//   - FB_ADDR_W: width of the frame buffer pixel address (640*480 pixels)
//   - vid_ctl_t: the sync/DE bundle that travels through the read-latency pipeline
package vga_timing_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int H_FP_DEF     = 16;
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BP_DEF     = 48;

   localparam int V_ACTIVE_DEF = 480;
   localparam int V_FP_DEF     = 10;
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BP_DEF     = 33;

   localparam int FB_ADDR_W = 19;

   typedef struct packed {
      logic hsync;
      logic vsync;
      logic de;
   } vid_ctl_t;

   function automatic int h_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int v_total(int active, int fp, int sync, int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing
//   Horizontal/vertical position counters and the raw (undelayed) control
//   signals derived from them. Everything advances only on ce.
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ce           in   pixel clock enable
//   raw          out  raw hsync / vsync / de for the current position
//   active       out  current position is inside the visible area
//   last_active  out  current position is the last visible pixel of the frame
//   frame_wrap   out  current position is the last position of the frame
//   vblank_start out  first vblank position, qualified by ce
module vga_timing
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int H_FP     = H_FP_DEF,
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BP     = H_BP_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF,
   parameter int V_FP     = V_FP_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BP     = V_BP_DEF,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     ce,
   output vid_ctl_t raw,
   output logic     active,
   output logic     last_active,
   output logic     frame_wrap,
   output logic     vblank_start
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_MAX   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
   localparam logic [HW-1:0] H_SS    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE    = HW'(H_ACTIVE + H_FP + H_SYNC);

   localparam logic [VW-1:0] V_MAX   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_ALAST = VW'(V_ACTIVE - 1);
   localparam logic [VW-1:0] V_SS    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE    = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_sync_win;
   logic          v_sync_win;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (ce) begin
         if (h_cnt == H_MAX) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   assign h_sync_win   = (h_cnt >= H_SS) && (h_cnt < H_SE);
   assign v_sync_win   = (v_cnt >= V_SS) && (v_cnt < V_SE);

   assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign last_active  = (h_cnt == H_ALAST) && (v_cnt == V_ALAST);
   assign frame_wrap   = (h_cnt == H_MAX) && (v_cnt == V_MAX);
   assign vblank_start = ce && (h_cnt == '0) && (v_cnt == V_ACT);

   assign raw.hsync    = h_sync_win ? SYNC_POL : ~SYNC_POL;
   assign raw.vsync    = v_sync_win ? SYNC_POL : ~SYNC_POL;
   assign raw.de       = active;

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout
//   Display-side consumer of the double-buffered 1-bpp frame buffer.
//   Walks the frame buffer with a linear read address, delays sync/DE by the
//   RAM read latency so they line up with rd_data, and grants the renderer's
//   swap request only at vblank start so a frame is never shown torn.
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   ce           in   pixel clock enable; all state advances only when ce=1
//   swap_req     in   renderer: back buffer complete (level)
//   swap         out  frame buffer swap strobe, one ce cycle
//   swap_done    out  renderer acknowledge, same cycle as swap
//   vblank_start out  one ce cycle at the first vblank pixel
//   rd_addr      out  frame buffer read address (y*H_ACTIVE + x)
//   rd_data      in   frame buffer read data, RD_LATENCY ce cycles after rd_addr
//   hsync        out  horizontal sync, aligned to pixel
//   vsync        out  vertical sync, aligned to pixel
//   de           out  display enable, aligned to pixel
//   pixel        out  rd_data gated by de
//   RD_LATENCY must be 1..3.
module fb_scanout
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_ACTIVE   = V_ACTIVE_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter bit SYNC_POL   = 1'b0,
   parameter int RD_LATENCY = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic                 swap_req,
   output logic                 swap,
   output logic                 swap_done,
   output logic                 vblank_start,
   output logic [FB_ADDR_W-1:0] rd_addr,
   input  logic                 rd_data,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic                 pixel
);

   localparam vid_ctl_t CTL_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, de: 1'b0};

   vid_ctl_t raw;
   vid_ctl_t dly [RD_LATENCY];
   logic     active;
   logic     last_active;
   logic     frame_wrap;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .ce           (ce),
      .raw          (raw),
      .active       (active),
      .last_active  (last_active),
      .frame_wrap   (frame_wrap),
      .vblank_start (vblank_start)
   );

   // rd_addr always names the pixel at the current position. It steps after
   // each visible pixel, so through horizontal blanking it already holds the
   // first address of the next line. After the last visible pixel it parks on
   // the final address until the frame wraps back to (0,0).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr <= '0;
         for (int i = 0; i < RD_LATENCY; i++) dly[i] <= CTL_IDLE;
      end else if (ce) begin
         dly[0] <= raw;
         for (int i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
         if (frame_wrap)
            rd_addr <= '0;
         else if (active && !last_active)
            rd_addr <= rd_addr + 1'b1;
      end
   end

   assign hsync = dly[RD_LATENCY-1].hsync;
   assign vsync = dly[RD_LATENCY-1].vsync;
   assign de    = dly[RD_LATENCY-1].de;
   assign pixel = dly[RD_LATENCY-1].de & rd_data;

   // vblank_start is already ce-qualified and occurs once per frame, which
   // bounds the grant to one swap per frame even with swap_req held high.
   // Reset holds the counters at (0,0), so no grant can appear around reset.
   assign swap      = vblank_start & swap_req;
   assign swap_done = swap;

endmodule
